// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - register-read and display bus for display_scheduler
//
// Purpose: groups everything the scheduler exchanges with the register file,
// the step button and the seven-segment digit drivers.
// Ports (signals):
//   pc[7:0]        program counter, binary
//   reg_data[7:0]  register-file read data for reg_addr (one cycle later)
//   btn_next       debounced, synchronous step request (level)
//   auto_en        enables periodic refresh
//   reg_addr[3:0]  register index being displayed
//   pc1, pc2       PC tens / units digit (4'hF = blank)
//   regpart1/2     register tens / units digit (4'hF = blank)
//   final_idx[3:0] register index belonging to the displayed sample
//   estado[3:0]    FSM state code
//   busy           conversion in progress
//   done           one-cycle pulse when the digits update
// Modports: master = scheduler, slave = surrounding system.
interface display_scheduler_if;
  logic [7:0] pc;
  logic [7:0] reg_data;
  logic       btn_next;
  logic       auto_en;
  logic [3:0] reg_addr;
  logic [3:0] pc1;
  logic [3:0] pc2;
  logic [3:0] regpart1;
  logic [3:0] regpart2;
  logic [3:0] final_idx;
  logic [3:0] estado;
  logic       busy;
  logic       done;

  modport master (
    input  pc, reg_data, btn_next, auto_en,
    output reg_addr, pc1, pc2, regpart1, regpart2, final_idx, estado, busy, done
  );

  modport slave (
    output pc, reg_data, btn_next, auto_en,
    input  reg_addr, pc1, pc2, regpart1, regpart2, final_idx, estado, busy, done
  );
endinterface

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - schedules PC/register binary-to-decimal display updates
//
// Purpose: on a button step or a periodic refresh, samples pc and the selected
// register, converts both to two decimal digits with double dabble and latches
// the result for the display.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    display_scheduler_if.master (see interface file for signal list)
module display_scheduler #(
  parameter int REFRESH_CYCLES = 25000000,
  parameter int NUM_REGS       = 10
) (
  input logic                  clk,
  input logic                  reset,
  display_scheduler_if.master  bus
);

  localparam int CW = $clog2(REFRESH_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_CONV  = 4'd2,
    S_LATCH = 4'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ref_cnt;
  logic          ref_wrap;
  logic          step_pend, ref_pend;
  logic          btn_prev;
  logic          btn_rise;
  logic          launch;
  logic [3:0]    step_cnt;
  // Shift registers laid out as {hundreds, tens, units, binary}.
  logic [19:0]   pc_sr, rd_sr;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // A non-zero hundreds digit means the value does not fit in two digits.
  function automatic logic [7:0] to_digits(input logic [19:0] v);
    return (v[19:16] != 4'd0) ? 8'hFF : v[15:8];
  endfunction

  assign btn_rise = bus.btn_next & ~btn_prev;
  assign ref_wrap = bus.auto_en && (ref_cnt == CW'(REFRESH_CYCLES - 1));
  assign launch   = (state == S_IDLE) && (step_pend || ref_pend);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (step_pend || ref_pend) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_CONV;
      S_CONV:  if (step_cnt == 4'd7) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.busy   = (state != S_IDLE);
    bus.estado = state;
  end

  // Datapath, request tracking and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.reg_addr  <= 4'd0;
      bus.final_idx <= 4'd0;
      bus.pc1       <= 4'hF;
      bus.pc2       <= 4'hF;
      bus.regpart1  <= 4'hF;
      bus.regpart2  <= 4'hF;
      bus.done      <= 1'b0;
      ref_cnt       <= '0;
      step_pend     <= 1'b0;
      // Forces a conversion of register 0 right after reset.
      ref_pend      <= 1'b1;
      btn_prev      <= bus.btn_next;
      step_cnt      <= 4'd0;
      pc_sr         <= '0;
      rd_sr         <= '0;
    end else begin
      btn_prev <= bus.btn_next;
      bus.done <= (state == S_LATCH);

      if (!bus.auto_en)  ref_cnt <= '0;
      else if (ref_wrap) ref_cnt <= '0;
      else               ref_cnt <= ref_cnt + CW'(1);

      // A new request arriving on the launch edge survives the clear.
      step_pend <= btn_rise | (step_pend & ~launch);
      ref_pend  <= ref_wrap | (ref_pend & ~launch);

      if (launch && step_pend) begin
        if (bus.reg_addr == 4'(NUM_REGS - 1)) bus.reg_addr <= 4'd0;
        else                                  bus.reg_addr <= bus.reg_addr + 4'd1;
      end

      case (state)
        S_FETCH: begin
          pc_sr    <= {12'd0, bus.pc};
          rd_sr    <= {12'd0, bus.reg_data};
          step_cnt <= 4'd0;
        end
        S_CONV: begin
          pc_sr    <= dd_step(pc_sr);
          rd_sr    <= dd_step(rd_sr);
          step_cnt <= step_cnt + 4'd1;
        end
        S_LATCH: begin
          {bus.pc1, bus.pc2}           <= to_digits(pc_sr);
          {bus.regpart1, bus.regpart2} <= to_digits(rd_sr);
          bus.final_idx                <= bus.reg_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed self-checking bench for display_scheduler
module tb_display_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n;

  display_scheduler_if bus ();

  display_scheduler #(
    .REFRESH_CYCLES(16),
    .NUM_REGS      (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until done is seen; -1 when the budget runs out.
  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.done !== 1'b1 && cnt < budget);
    if (bus.done !== 1'b1) cnt = -1;
  endtask

  task automatic count_dones(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done === 1'b1) k++;
    end
  endtask

  task automatic pulse_btn();
    bus.btn_next = 1'b1;
    @(negedge clk);
    bus.btn_next = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.pc       = 8'd42;
    bus.reg_data = 8'd7;
    bus.btn_next = 1'b0;
    bus.auto_en  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy",     bus.busy,      1'b0);
    check("rst_done",     bus.done,      1'b0);
    check("rst_estado",   bus.estado,    4'd0);
    check("rst_reg_addr", bus.reg_addr,  4'd0);
    check("rst_final",    bus.final_idx, 4'd0);
    check("rst_pc1",      bus.pc1,       4'hF);
    check("rst_pc2",      bus.pc2,       4'hF);
    check("rst_regpart1", bus.regpart1,  4'hF);
    check("rst_regpart2", bus.regpart2,  4'hF);

    // Reset release launches a conversion of register 0 immediately
    reset = 1'b0;
    @(negedge clk);
    check("rel_estado_fetch", bus.estado, 4'd1);
    check("rel_busy",         bus.busy,   1'b1);
    repeat (9) @(negedge clk);
    check("rel_estado_latch", bus.estado, 4'd3);
    check("rel_pc1_early",    bus.pc1,    4'hF);
    @(negedge clk);
    check("rel_done",     bus.done,      1'b1);
    check("rel_pc1",      bus.pc1,       4'd4);
    check("rel_pc2",      bus.pc2,       4'd2);
    check("rel_regpart1", bus.regpart1,  4'd0);
    check("rel_regpart2", bus.regpart2,  4'd7);
    check("rel_final",    bus.final_idx, 4'd0);
    check("rel_busy_end", bus.busy,      1'b0);
    @(negedge clk);
    check("rel_done_once", bus.done, 1'b0);
    count_dones(30, n);
    check("rel_no_more_done", n, 0);

    // Step through registers 1..9 with out-of-range pc
    bus.pc       = 8'd150;
    bus.reg_data = 8'd99;
    for (int i = 1; i <= 9; i++) begin
      pulse_btn();
      wait_done(40, n);
      check("step_done_seen", n > 0, 1'b1);
      check("step_reg_addr", bus.reg_addr, i);
      if (i == 1) begin
        check("blank_pc1",  bus.pc1,      4'hF);
        check("blank_pc2",  bus.pc2,      4'hF);
        check("r99_part1",  bus.regpart1, 4'd9);
        check("r99_part2",  bus.regpart2, 4'd9);
        check("step_final", bus.final_idx, 4'd1);
      end
    end
    check("step9_final", bus.final_idx, 4'd9);

    // Wrap 9 -> 0
    pulse_btn();
    wait_done(40, n);
    check("wrap_done_seen", n > 0, 1'b1);
    check("wrap_reg_addr",  bus.reg_addr,  4'd0);
    check("wrap_final",     bus.final_idx, 4'd0);

    // Three presses during one busy period add exactly one more increment
    pulse_btn();
    check("multi_busy",  bus.busy,     1'b1);
    check("multi_addr1", bus.reg_addr, 4'd1);
    repeat (3) pulse_btn();
    check("multi_addr_hold", bus.reg_addr, 4'd1);
    wait_done(40, n);
    check("multi_done1_seen", n > 0, 1'b1);
    check("multi_final1", bus.final_idx, 4'd1);
    wait_done(40, n);
    check("multi_done2_seen", n > 0, 1'b1);
    check("multi_addr2",  bus.reg_addr,  4'd2);
    check("multi_final2", bus.final_idx, 4'd2);
    count_dones(40, n);
    check("multi_no_more_done", n, 0);

    // Periodic refresh every 16 cycles
    bus.auto_en = 1'b1;
    wait_done(40, n);
    check("auto_first_seen", n > 0, 1'b1);
    wait_done(40, n);
    check("auto_period1", n, 16);
    wait_done(40, n);
    check("auto_period2", n, 16);
    check("auto_reg_addr", bus.reg_addr, 4'd2);
    bus.auto_en = 1'b0;
    count_dones(50, n);
    check("auto_off_no_done", n, 0);

    // Reset during CONV cycle 4 aborts the conversion
    bus.btn_next = 1'b1;
    @(negedge clk);
    bus.btn_next = 1'b0;
    @(negedge clk);
    check("abort_fetch", bus.estado, 4'd1);
    repeat (4) @(negedge clk);
    check("abort_conv", bus.estado, 4'd2);
    reset = 1'b1;
    @(negedge clk);
    check("abort_pc1",      bus.pc1,       4'hF);
    check("abort_regpart1", bus.regpart1,  4'hF);
    check("abort_regpart2", bus.regpart2,  4'hF);
    check("abort_busy",     bus.busy,      1'b0);
    check("abort_done",     bus.done,      1'b0);
    check("abort_reg_addr", bus.reg_addr,  4'd0);
    check("abort_estado",   bus.estado,    4'd0);
    bus.pc       = 8'd42;
    bus.reg_data = 8'd7;
    reset = 1'b0;
    wait_done(20, n);
    check("abort_latency",  n,             11);
    check("abort_pc1_new",  bus.pc1,       4'd4);
    check("abort_pc2_new",  bus.pc2,       4'd2);
    check("abort_rp1_new",  bus.regpart1,  4'd0);
    check("abort_rp2_new",  bus.regpart2,  4'd7);
    check("abort_final",    bus.final_idx, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
